// File: rtl/adder_sum_accumulator_pkg.sv
// Shared types, constants and the saturating add used by the sample accumulator.
package adder_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } acc_state_e;

    localparam int DEFAULT_ACC_W = 16;
    localparam int NUM_BYTES     = DEFAULT_ACC_W / 8;

    // Widest accumulator sat_add can handle; acc_w must stay strictly below it.
    localparam int MAX_ACC_W = 64;

    // Adds two acc_w-bit values. Returns {overflow, result}. On overflow the
    // result is clamped to all-ones when saturate is set, otherwise it wraps.
    function automatic logic [MAX_ACC_W:0] sat_add(
        input logic [MAX_ACC_W-1:0] acc,
        input logic [MAX_ACC_W-1:0] val,
        input int unsigned          acc_w,
        input logic                 saturate
    );
        logic [MAX_ACC_W:0] sum;
        logic [MAX_ACC_W:0] limit;
        logic               over;
        sum   = {1'b0, acc} + {1'b0, val};
        limit = ((MAX_ACC_W+1)'(1) << acc_w) - (MAX_ACC_W+1)'(1);
        over  = (sum > limit);
        if (over) begin
            sum = saturate ? limit : (sum & limit);
        end
        return {over, sum[MAX_ACC_W-1:0]};
    endfunction

endpackage

// File: rtl/adder_sum_accumulator_if.sv
// Sample-in / byte-out handshake bundle of the adder sum accumulator.
interface adder_sum_accumulator_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_carry;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    // Upstream producer and downstream consumer side.
    modport master (
        output in_data, in_carry, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    // The accumulator itself.
    modport slave (
        input  in_data, in_carry, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/adder_sum_accumulator_acc_byte_serializer.sv
// Holds a captured accumulator word and presents it byte by byte, low byte
// first, on a registered valid/ready stream. done pulses with the last transfer.
module acc_byte_serializer #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [ACC_W-1:0] load_word,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             done
);
    localparam int N_BYTES = ACC_W / 8;
    localparam int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    logic [N_BYTES-1:0][7:0] word;
    logic [IDX_W-1:0]        byte_idx;
    logic [IDX_W-1:0]        idx_nxt;
    logic                    xfer;

    assign xfer    = out_valid && out_ready;
    assign idx_nxt = byte_idx + IDX_W'(1);
    assign done    = xfer && out_last;

    // Load a fresh word, or step to the next byte after each accepted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word      <= '0;
            byte_idx  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (clear) begin
            word      <= '0;
            byte_idx  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            word      <= load_word;
            byte_idx  <= '0;
            out_data  <= load_word[7:0];
            out_valid <= 1'b1;
            out_last  <= (N_BYTES == 1);
        end else if (xfer) begin
            if (out_last) begin
                byte_idx  <= '0;
                out_data  <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                byte_idx  <= idx_nxt;
                out_data  <= word[idx_nxt];
                out_last  <= (idx_nxt == IDX_W'(N_BYTES - 1));
            end
        end
    end
endmodule

// File: rtl/adder_sum_accumulator.sv
// Accumulates NUM_SAMPLES {carry, sum} adder results, then drains the total
// byte-serially so sums wider than the 8 output pins can be reported.
//
//  state | meaning
//  ACCUM | accepting samples, in_ready high
//  DRAIN | serializer owns the output, input ignored
module adder_sum_accumulator
    import adder_acc_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ACC_W       = DEFAULT_ACC_W,
    parameter int NUM_SAMPLES = 4,
    parameter int SATURATE    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    adder_sum_accumulator_if.slave  bus,
    output logic                    ovf,
    output logic                    busy
);
    if (ACC_W % 8 != 0 || ACC_W <= DATA_W + 1 || ACC_W >= MAX_ACC_W) begin : g_bad_acc_w
        $error("adder_sum_accumulator: illegal ACC_W");
    end
    if (NUM_SAMPLES < 1 || NUM_SAMPLES > 255) begin : g_bad_num_samples
        $error("adder_sum_accumulator: illegal NUM_SAMPLES");
    end

    acc_state_e       state, state_next;
    logic [ACC_W-1:0] acc, acc_next;
    logic [7:0]       cnt, cnt_next;
    logic             ovf_q, ovf_next;
    logic             load;
    logic             done;
    logic [MAX_ACC_W:0] add_res;
    logic             unused_hi;

    assign add_res   = sat_add(MAX_ACC_W'(acc), MAX_ACC_W'({bus.in_carry, bus.in_data}),
                               ACC_W, (SATURATE != 0));
    assign unused_hi = ^add_res[MAX_ACC_W-1:ACC_W];

    assign bus.in_ready = (state == ACCUM);
    assign busy         = (cnt != 8'd0) || (state == DRAIN);
    assign ovf          = ovf_q;

    // Next state and accumulator update; clear overrides any handshake.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        ovf_next   = ovf_q;
        load       = 1'b0;
        if (clear) begin
            state_next = ACCUM;
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc_next = add_res[ACC_W-1:0];
                        ovf_next = ovf_q | add_res[MAX_ACC_W];
                        cnt_next = cnt + 8'd1;
                        if (cnt == 8'(NUM_SAMPLES - 1)) begin
                            state_next = DRAIN;
                            load       = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (done) begin
                        state_next = ACCUM;
                        acc_next   = '0;
                        cnt_next   = '0;
                        ovf_next   = 1'b0;
                    end
                end
                default: state_next = ACCUM;
            endcase
        end
    end

    // State, accumulator, sample counter and sticky overflow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            ovf_q <= ovf_next;
        end
    end

    // The serializer captures the post-add value so byte 0 is out one edge after the last accept.
    acc_byte_serializer #(
        .ACC_W (ACC_W)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .load      (load),
        .load_word (acc_next),
        .out_data  (bus.out_data),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_last  (bus.out_last),
        .done      (done)
    );
endmodule
